buf_read_seq: RTL and testbench

BUF_READ_SEQ -- requirements
Module: buf_read_seq

---
 rtl/lenet_buf_pkg.sv | 8 +
 rtl/buf_read_skid.sv | 49 ++++
 rtl/buf_read_seq.sv | 118 +++++++++++
 tb/tb_buf_read_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_buf_pkg.sv
// lenet_buf_pkg: shared state encodings and FIFO depth for the buffer read sequencer
package lenet_buf_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/buf_read_skid.sv
// buf_read_skid: 2-entry FIFO holding read data until downstream accepts it
module buf_read_skid
    import lenet_buf_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [BW-1:0] i_din,
    input  logic          i_pop,
    output logic [BW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);
    logic [1:0]    cnt;
    logic [BW-1:0] head;
    logic [BW-1:0] tail;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = i_pop && cnt != 2'd0;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_full  = cnt == 2'(FIFO_DEPTH);
    assign o_empty = cnt == 2'd0;
    assign o_dout  = head;

    // head is the oldest word; tail only holds a second word when two are queued
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (i_clr) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
            if (do_pop && cnt == 2'd2)
                head <= tail;
            else if (do_push && (cnt == 2'd0 || do_pop))
                head <= i_din;
            if (do_push && (cnt - 2'(do_pop)) == 2'd1)
                tail <= i_din;
        end
    end
endmodule

// File: rtl/buf_read_seq.sv
// buf_read_seq: reads a buffer CNT_DEPTH words per pass and streams it out; BUF_READ_SEQ_STALL_CNT_EN adds o_stall_cnt
module buf_read_seq
    import lenet_buf_pkg::*;
#(
    parameter int BW         = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int CNT_DEPTH  = 16,
    parameter int PASS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  i_rst,
    input  logic                  i_load_done,
    input  logic                  i_start,
    input  logic [PASS_WIDTH-1:0] i_num_pass,
    output logic                  o_rd_en,
    output logic [CNT_WIDTH-1:0]  o_rd_addr,
    input  logic [BW-1:0]         i_rd_data,
    output logic [BW-1:0]         o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [PASS_WIDTH-1:0] o_pass_idx
`ifdef BUF_READ_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);
    logic [1:0]            state;
    logic [PASS_WIDTH-1:0] num_pass;
    logic                  rd_vld;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            occ;
    logic [2:0]            pend;
    logic                  issue_ok;
    logic                  start;
    logic                  addr_end;
    logic                  last_rd;

    assign o_valid  = !fifo_empty;
    assign o_busy   = state == ST_RUN || state == ST_DRAIN;
    assign o_done   = state == ST_DONE;
    assign start    = state == ST_IDLE && i_start && i_load_done;
    assign occ      = {fifo_full, !fifo_full && !fifo_empty};
    // words that will occupy the FIFO after this edge, counting the read on the bus and the one being issued
    assign pend     = 3'(occ) + 3'(rd_vld) + 3'(o_rd_en) - 3'(o_valid && i_ready);
    assign issue_ok = pend < 3'(FIFO_DEPTH);
    assign addr_end = o_rd_addr == CNT_WIDTH'(CNT_DEPTH - 1);
    assign last_rd  = o_rd_en && addr_end && o_pass_idx == num_pass - PASS_WIDTH'(1);

    buf_read_skid #(.BW(BW)) u_fifo (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .i_clr        (i_rst),
        .i_push       (rd_vld),
        .i_din        (i_rd_data),
        .i_pop        (i_ready),
        .o_dout       (o_data),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty)
    );

    // sequencer: issues reads only while the FIFO can absorb every outstanding word
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state      <= ST_IDLE;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_pass_idx <= '0;
            num_pass   <= '0;
            rd_vld     <= 1'b0;
        end else if (i_rst) begin
            state      <= ST_IDLE;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_pass_idx <= '0;
            num_pass   <= '0;
            rd_vld     <= 1'b0;
        end else begin
            rd_vld <= o_rd_en;
            case (state)
                ST_IDLE: if (start) begin
                    state      <= ST_RUN;
                    o_rd_en    <= 1'b1;
                    o_rd_addr  <= '0;
                    o_pass_idx <= '0;
                    num_pass   <= (i_num_pass == '0) ? PASS_WIDTH'(1) : i_num_pass;
                end
                ST_RUN: begin
                    if (o_rd_en) begin
                        o_rd_addr <= addr_end ? '0 : o_rd_addr + CNT_WIDTH'(1);
                        if (addr_end && !last_rd)
                            o_pass_idx <= o_pass_idx + PASS_WIDTH'(1);
                    end
                    o_rd_en <= !last_rd && issue_ok;
                    if (last_rd)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: if (fifo_empty && !rd_vld) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BUF_READ_SEQ_STALL_CNT_EN
    // saturating count of cycles where a word waits on downstream
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)
            o_stall_cnt <= '0;
        else if (i_rst || start)
            o_stall_cnt <= '0;
        else if (o_valid && !i_ready && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_buf_read_seq.sv
// tb_buf_read_seq: directed self-checking bench for buf_read_seq
module tb_buf_read_seq;
    logic       clk = 1'b0;
    logic       global_rst_n = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_load_done = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_num_pass = 4'd1;
    logic       o_rd_en;
    logic [3:0] o_rd_addr;
    logic [7:0] i_rd_data = 8'h00;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_pass_idx;
`ifdef BUF_READ_SEQ_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int stall_model = 0;

    always #5 clk = ~clk;

    // memory model: one-cycle read latency, word at address a is {~a, a}
    always @(posedge clk) i_rd_data <= o_rd_en ? {~o_rd_addr, o_rd_addr} : 8'hA5;

    buf_read_seq dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .i_rst        (i_rst),
        .i_load_done  (i_load_done),
        .i_start      (i_start),
        .i_num_pass   (i_num_pass),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass_idx   (o_pass_idx)
`ifdef BUF_READ_SEQ_STALL_CNT_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdat(input int k);
        logic [3:0] a;
        a = 4'(k % 16);
        return {~a, a};
    endfunction

    task automatic start_run(input logic [3:0] np);
        @(negedge clk);
        i_num_pass  = np;
        i_load_done = 1'b1;
        i_start     = 1'b1;
        i_ready     = 1'b1;
    endtask

    // mode 0: ready high, 1: ready toggles, 2: 10-cycle stall after word 5, 3: 7-cycle stall while valid
    task automatic collect(input int nwords, input int mode, input int abort_at);
        int got = 0;
        int issued = 0;
        int cyc = 0;
        int first_v = -1;
        int stall_rem = 0;
        int dones = 0;
        bit stalled = 1'b0;
        logic pv = 1'b0;
        logic pr = 1'b1;
        logic [7:0] pd = 8'h00;
        stall_model = 0;
        while ((got < nwords || dones == 0) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            if (mode == 2 && !stalled && got == 5) begin stalled = 1'b1; stall_rem = 10; end
            if (mode == 3 && !stalled && got >= 3 && o_valid) begin stalled = 1'b1; stall_rem = 7; end
            if (mode == 1) i_ready = (cyc % 2) == 1;
            else i_ready = (stall_rem == 0);
            if (stall_rem > 0) stall_rem--;
            if (pv && !pr) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, pd);
            end
            if (o_rd_en) begin
                chk("rd_addr", o_rd_addr, issued % 16);
                chk("pass_idx", o_pass_idx, issued / 16);
                issued++;
            end
            chk("outstanding_le_2", 32'(issued - got <= 2), 1);
            chk("no_overread", 32'(issued <= nwords), 1);
            if (o_valid && first_v < 0) first_v = cyc;
            if (o_valid && !i_ready) stall_model++;
            if (o_valid && i_ready) begin
                chk("data", o_data, mdat(got));
                got++;
            end
            if (o_done) begin
                dones++;
                chk("busy_at_done", o_busy, 0);
`ifdef BUF_READ_SEQ_STALL_CNT_EN
                chk("stall_cnt_at_done", o_stall_cnt, stall_model);
`endif
            end
            pv = o_valid;
            pr = i_ready;
            pd = o_data;
            if (got == abort_at) begin
                i_rst = 1'b1;
                return;
            end
        end
        chk("word_count", got, nwords);
        chk("first_valid_cycle", first_v, 3);
        chk("done_seen", dones, 1);
        @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("busy_after", o_busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass_idx", o_pass_idx, 0);
        global_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single pass, ready high
        start_run(4'd1);
        collect(16, 0, -1);

        // start without load_done is ignored
        @(negedge clk);
        i_load_done = 1'b0;
        i_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            chk("noload_rd_en", o_rd_en, 0);
            chk("noload_busy", o_busy, 0);
        end

        // three passes with toggling ready
        start_run(4'd3);
        collect(48, 1, -1);

        // pass count 0 behaves as 1
        start_run(4'd0);
        collect(16, 0, -1);

        // long stall mid-pass
        start_run(4'd1);
        collect(16, 2, -1);

        // sync clear at word 5 of pass 0
        start_run(4'd1);
        collect(16, 0, 5);
        @(negedge clk);
        i_rst = 1'b0;
        chk("srst_valid", o_valid, 0);
        chk("srst_rd_addr", o_rd_addr, 0);
        chk("srst_rd_en", o_rd_en, 0);
        chk("srst_busy", o_busy, 0);
        chk("srst_pass_idx", o_pass_idx, 0);
        // clear wins over start
        i_rst = 1'b1;
        i_start = 1'b1;
        i_load_done = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        chk("srst_prio_busy", o_busy, 0);
        chk("srst_prio_rd_en", o_rd_en, 0);
        start_run(4'd1);
        collect(16, 0, -1);

        // exactly seven stall cycles in one run
        start_run(4'd1);
        collect(16, 3, -1);
`ifdef BUF_READ_SEQ_STALL_CNT_EN
        chk("stall_cnt_7", o_stall_cnt, 7);
`endif

        // async reset mid-run, then no resume
        start_run(4'd2);
        repeat (4) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        global_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_rd_en", o_rd_en, 0);
        chk("arst_rd_addr", o_rd_addr, 0);
        chk("arst_data", o_data, 0);
        @(negedge clk);
        global_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_resume_busy", o_busy, 0);
            chk("arst_no_resume_rd_en", o_rd_en, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
